// File: rtl/msb_index_pipe_if.sv
// rtl/msb_index_pipe_if.sv - input/output stream bundle for the set-bit index encoder
interface msb_index_pipe_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_lsb;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_index;
    logic             out_zero;

    modport slave (
        input  in_valid, in_data, in_lsb, out_ready,
        output in_ready, out_valid, out_index, out_zero
    );

    modport master (
        output in_valid, in_data, in_lsb, out_ready,
        input  in_ready, out_valid, out_index, out_zero
    );
endinterface

// File: rtl/msb_index_pipe.sv
// rtl/msb_index_pipe.sv - two-stage pipelined highest/lowest set-bit index encoder
module msb_index_pipe #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    msb_index_pipe_if.slave    bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_smear;
    logic             s1_lsb;
    logic             s2_valid;
    logic [IDXW-1:0]  s2_index;
    logic             s2_zero;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] src_word;
    logic [WIDTH-1:0] smear;
    logic [WIDTH-1:0] onehot;
    logic [IDXW-1:0]  msb_idx;
    logic [IDXW-1:0]  enc_idx;
    logic             enc_zero;

    assign advance = !s2_valid || bus.out_ready;
    assign accept  = !s1_valid || advance;

    assign bus.in_ready  = accept;
    assign bus.out_valid = s2_valid;
    assign bus.out_index = s2_index;
    assign bus.out_zero  = s2_zero;

    // LSB mode searches the bit-reversed word for its MSB.
    always_comb begin
        src_word = '0;
        for (int p = 0; p < WIDTH; p++) begin
            src_word[p] = bus.in_lsb ? bus.in_data[WIDTH-1-p] : bus.in_data[p];
        end
        smear = src_word;
        for (int k = 0; k < IDXW; k++) begin
            smear = smear | (smear >> (1 << k));
        end
    end

    always_comb begin
        onehot  = s1_smear & ~(s1_smear >> 1);
        msb_idx = '0;
        for (int k = 0; k < IDXW; k++) begin
            for (int p = 0; p < WIDTH; p++) begin
                if (((p >> k) & 1) == 1) begin
                    msb_idx[k] = msb_idx[k] | onehot[p];
                end
            end
        end
        enc_zero = ~|s1_smear;
        if (enc_zero) begin
            enc_idx = '0;
        end else if (s1_lsb) begin
            enc_idx = IDXW'(WIDTH - 1) - msb_idx;
        end else begin
            enc_idx = msb_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_smear <= '0;
            s1_lsb   <= 1'b0;
            s2_valid <= 1'b0;
            s2_index <= '0;
            s2_zero  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_smear <= smear;
                    s1_lsb   <= bus.in_lsb;
                end
            end
            if (advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_index <= enc_idx;
                    s2_zero  <= enc_zero;
                end
            end
        end
    end
endmodule

// File: tb/tb_msb_index_pipe.sv
// tb/tb_msb_index_pipe.sv - directed and scoreboard bench for msb_index_pipe
module tb_msb_index_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    msb_index_pipe_if #(.WIDTH(32)) bus ();
    msb_index_pipe_if #(.WIDTH(8))  bus8 ();
    msb_index_pipe_if #(.WIDTH(64)) bus64 ();

    msb_index_pipe #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    msb_index_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    msb_index_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.in_valid = 1'b0;   bus.in_data = '0;   bus.in_lsb = 1'b0;   bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0;  bus8.in_data = '0;  bus8.in_lsb = 1'b0;  bus8.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_lsb = 1'b0; bus64.out_ready = 1'b0;
    endtask

    function automatic void model(input logic [31:0] d, input logic l, output int idx, output bit z);
        z = (d == 32'h0);
        idx = 0;
        if (!z) begin
            if (l) begin
                for (int p = 31; p >= 0; p--) if (d[p]) idx = p;
            end else begin
                for (int p = 0; p < 32; p++) if (d[p]) idx = p;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_index !== 5'd0) begin n_fail++; $display("FAIL reset_out_index: got %0d want 0", bus.out_index); end
        n_cmp++; if (bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b want 0", bus.out_zero); end
        n_cmp++; if (bus8.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid_widths: got %b/%b want 0/0", bus8.out_valid, bus64.out_valid);
        end
    endtask

    task automatic test_msb_stream();
        logic [31:0] w [3];
        int e [3];
        w = '{32'h8000_0000, 32'h0000_0001, 32'h0001_0F00};
        e = '{31, 0, 16};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                bus.in_valid = 1'b1; bus.in_data = w[i]; bus.in_lsb = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== e[i-1][4:0] || bus.out_zero !== 1'b0) begin
                    n_fail++; $display("FAIL msb_stream[%0d]: got v=%b idx=%0d z=%b want v=1 idx=%0d z=0",
                                       i-1, bus.out_valid, bus.out_index, bus.out_zero, e[i-1]);
                end
            end else begin
                n_cmp++; if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL msb_stream_idle cycle %0d: got v=%b want 0", i, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_lsb_and_zero();
        logic [31:0] w [7];
        bit l [7];
        int e [7];
        bit z [7];
        w = '{32'h0001_0F00, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000};
        l = '{1, 1, 0, 1, 0, 1, 1};
        e = '{8, 0, 0, 0, 31, 0, 31};
        z = '{0, 0, 1, 1, 0, 0, 0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 7) begin
                bus.in_valid = 1'b1; bus.in_data = w[i]; bus.in_lsb = l[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 7) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== e[i-1][4:0] || bus.out_zero !== z[i-1]) begin
                    n_fail++; $display("FAIL lsb_zero[%0d]: got v=%b idx=%0d z=%b want v=1 idx=%0d z=%0d",
                                       i-1, bus.out_valid, bus.out_index, bus.out_zero, e[i-1], z[i-1]);
                end
            end
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_zero_drain: got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] w [5];
        bit l [5];
        int e [5];
        bit z [5];
        bit or_t [11];
        bit iv_t [11];
        bit rdy_t [11];
        int out_t [11];
        int ptr = 0;
        w = '{32'h0000_0400, 32'h0F00_0000, 32'h7000_0000, 32'h0000_0006, 32'h0};
        l = '{0, 1, 0, 0, 0};
        e = '{10, 24, 30, 2, 0};
        z = '{0, 0, 0, 0, 1};
        or_t  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        iv_t  = '{1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        rdy_t = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        out_t = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, 4, -1};
        for (int c = 0; c < 11; c++) begin
            bus.out_ready = or_t[c];
            bus.in_valid = iv_t[c] && (ptr < 5);
            if (ptr < 5) begin
                bus.in_data = w[ptr]; bus.in_lsb = l[ptr];
            end
            #1;
            n_cmp++; if (bus.in_ready !== rdy_t[c]) begin
                n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b want %0d", c, bus.in_ready, rdy_t[c]);
            end
            if (out_t[c] >= 0) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== e[out_t[c]][4:0] || bus.out_zero !== z[out_t[c]]) begin
                    n_fail++; $display("FAIL bp_out cycle %0d: got v=%b idx=%0d z=%b want v=1 idx=%0d z=%0d",
                                       c, bus.out_valid, bus.out_index, bus.out_zero, e[out_t[c]], z[out_t[c]]);
                end
            end else begin
                n_cmp++; if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL bp_out_idle cycle %0d: got v=%b want 0", c, bus.out_valid);
                end
            end
            if (bus.in_valid && bus.in_ready) ptr++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (ptr != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", ptr); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_lsb = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h0000_FFFF; tick();
        bus.in_valid = 1'b1; bus.in_data = 32'h0000_0010; tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_loaded: got v=%b want 1", bus.out_valid); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_hold[%0d]: got v=%b want 0", i, bus.out_valid); end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed[%0d]: got v=%b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        localparam int NW = 10000;
        int exp_idx [$];
        bit exp_zero [$];
        int sent = 0;
        int got = 0;
        bit hold = 0;
        logic [4:0] prev_idx = '0;
        logic prev_zero = 1'b0;
        int mi;
        bit mz;
        logic [31:0] d;
        for (int c = 0; c < 60000 && got < NW; c++) begin
            case ($urandom_range(3))
                0: d = $urandom;
                1: d = 32'h1 << $urandom_range(31);
                2: d = $urandom & $urandom & $urandom;
                default: d = ($urandom_range(1) == 1) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
            bus.in_valid = (sent < NW) && ($urandom_range(3) != 0);
            bus.in_data = d;
            bus.in_lsb = 1'($urandom_range(1));
            bus.out_ready = (sent >= NW) || ($urandom_range(3) != 0);
            #1;
            if (hold) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== prev_idx || bus.out_zero !== prev_zero) begin
                    n_fail++; if (n_fail < 40) $display("FAIL rand_hold cycle %0d: got v=%b idx=%0d z=%b want v=1 idx=%0d z=%b",
                                                        c, bus.out_valid, bus.out_index, bus.out_zero, prev_idx, prev_zero);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_data, bus.in_lsb, mi, mz);
                exp_idx.push_back(mi);
                exp_zero.push_back(mz);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_idx.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra cycle %0d: got unexpected word want none", c);
                end else begin
                    mi = exp_idx.pop_front();
                    mz = exp_zero.pop_front();
                    if (bus.out_index !== mi[4:0] || bus.out_zero !== mz) begin
                        n_fail++; if (n_fail < 40) $display("FAIL rand_word %0d: got idx=%0d z=%b want idx=%0d z=%0d",
                                                            got, bus.out_index, bus.out_zero, mi, mz);
                    end
                end
                got++;
            end
            hold = bus.out_valid && !bus.out_ready;
            prev_idx = bus.out_index;
            prev_zero = bus.out_zero;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got != NW || exp_idx.size() != 0) begin
            n_fail++; $display("FAIL rand_count: got %0d results (%0d pending) want %0d (0 pending)", got, exp_idx.size(), NW);
        end
    endtask

    task automatic test_widths();
        logic [7:0]  d8 [6];
        bit          l8 [6];
        int          e8 [6];
        bit          z8 [6];
        logic [63:0] d64 [7];
        bit          l64 [7];
        int          e64 [7];
        bit          z64 [7];
        d8  = '{8'h80, 8'h01, 8'h14, 8'h14, 8'hFF, 8'h00};
        l8  = '{0, 0, 0, 1, 1, 1};
        e8  = '{7, 0, 4, 2, 0, 0};
        z8  = '{0, 0, 0, 0, 0, 1};
        d64 = '{64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0001_0000_0F00_0000,
                64'h0001_0000_0F00_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        l64 = '{0, 1, 0, 1, 0, 1, 0};
        e64 = '{0, 63, 63, 24, 48, 0, 0};
        z64 = '{0, 0, 0, 0, 0, 0, 1};
        bus8.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus8.in_valid = (i < 6);
            if (i < 6) begin bus8.in_data = d8[i]; bus8.in_lsb = l8[i]; end
            bus64.in_valid = (i < 7);
            if (i < 7) begin bus64.in_data = d64[i]; bus64.in_lsb = l64[i]; end
            tick();
            if (i >= 1 && i <= 6) begin
                n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.out_index !== e8[i-1][2:0] || bus8.out_zero !== z8[i-1]) begin
                    n_fail++; $display("FAIL w8[%0d]: got v=%b idx=%0d z=%b want v=1 idx=%0d z=%0d",
                                       i-1, bus8.out_valid, bus8.out_index, bus8.out_zero, e8[i-1], z8[i-1]);
                end
            end
            if (i >= 1 && i <= 7) begin
                n_cmp++; if (bus64.out_valid !== 1'b1 || bus64.out_index !== e64[i-1][5:0] || bus64.out_zero !== z64[i-1]) begin
                    n_fail++; $display("FAIL w64[%0d]: got v=%b idx=%0d z=%b want v=1 idx=%0d z=%0d",
                                       i-1, bus64.out_valid, bus64.out_index, bus64.out_zero, e64[i-1], z64[i-1]);
                end
            end
        end
        n_cmp++; if (bus8.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL widths_drain: got v8=%b v64=%b want 0/0", bus8.out_valid, bus64.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_msb_stream();
        test_lsb_and_zero();
        test_back_pressure();
        test_reset_midstream();
        test_random();
        test_widths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
